wb_regfile: RTL and testbench
=============================

# wb_regfile

Writeback-stage consumer of the MEM→WB pipeline register. Takes the W-stage control (RegWriteW, ResultSrcW) and data buses, selects the final result and commits it to the 32-entry integer register file. Serves the two decode-stage read ports with same-cycle write-through bypass. Maintains cycle and retired-instruction counters for performance monitoring.

## Interface

Parameters:
- DATA_WIDTH, 32, register and result width
- ADDR_WIDTH, 5, register index width; the file holds 2**ADDR_WIDTH entries
- COUNT_WIDTH, 64, width of the cycle and instret counters

Ports:
- clk  in  1  single clock; all state updates on posedge
- reset  in  1  synchronous, active-low; sampled low on a posedge resets all state
- RegWriteW  in  1  W-stage register write enable
- ResultSrcW  in  2  result select: 00 ALUResultW, 01 ReadDataW, 10 PCPlus4W, 11 ImmExtW
- ValidW  in  1  W stage holds a real instruction, not a bubble or flush
- RdW  in  ADDR_WIDTH  destination register index
- ALUResultW  in  DATA_WIDTH  ALU result
- ReadDataW  in  DATA_WIDTH  data-memory load result
- PCPlus4W  in  DATA_WIDTH  link address for JAL/JALR
- ImmExtW  in  DATA_WIDTH  extended immediate for LUI
- Rs1D, Rs2D  in  ADDR_WIDTH  decode-stage read indices
- ResultW  out  DATA_WIDTH  selected writeback value (also the forwarding source)
- RD1D, RD2D  out  DATA_WIDTH  decode-stage read data
- CycleCnt  out  COUNT_WIDTH  cycles since reset release
- InstretCnt  out  COUNT_WIDTH  instructions retired since reset release

## Operation

- ResultW is a combinational 4:1 mux on ResultSrcW. It is valid regardless of RegWriteW.
- Commit condition: `we = reset && RegWriteW && ValidW && (RdW != 0)`. On a posedge with `we` true, `regs[RdW] <= ResultW`.
- x0 is hardwired:
  - it is never written;
  - a read of index 0 returns 0;
  - bypass never fires for index 0.
- Read ports are combinational:
  - RD1D = 0 if Rs1D == 0;
  - else ResultW if `we` && RdW == Rs1D (write-through bypass);
  - else regs[Rs1D].
  - RD2D is the same, using Rs2D.
- With reset low, RD1D and RD2D are forced to 0.
- Both ports may read the same index, including the index being written. Both then return ResultW.
- Counters:
  - CycleCnt increments by 1 on every posedge with reset high.
  - InstretCnt increments by 1 on every posedge with reset high and ValidW high, independent of RegWriteW (stores and branches also retire).
  - Both wrap modulo 2**COUNT_WIDTH with no saturation and no flag.
- There is no state machine. State consists of the register array (entries 1..31) and the two counters.

## Timing

- Reset, on a posedge with reset low:
  - all entries 1..31 become 0;
  - CycleCnt = 0 and InstretCnt = 0;
  - any concurrent write is dropped.
- Reset asserted mid-operation drops the W-stage instruction in flight. There is no partial commit, and the instruction is not counted.
- First cycle after reset release:
  - counters read 0;
  - at the following posedge CycleCnt becomes 1.
- Write latency:
  - a value committed at posedge N is readable from the array from N onward;
  - in the cycle before N it is already visible through the bypass.
  - Decode therefore sees writeback data with zero added latency, and the hazard unit needs no W→D stall.
- Back-to-back writes to the same Rd: the last commit wins. Each one bypasses in its own cycle.
- Combinational paths: ResultSrcW/data → ResultW → RD1D/RD2D. This is a single mux plus a compare and mux, with no path through the counters.
- ValidW low with RegWriteW high (flushed instruction): no write, no instret increment. The bypass does not fire.

## Test plan

- **Reset clear:** write 0xDEADBEEF to x5, hold reset low 1 cycle, release. Required: Rs1D=5 reads 0, CycleCnt=0, InstretCnt=0. One cycle later CycleCnt=1.
- **Source select:** ALUResultW=0x11, ReadDataW=0x22, PCPlus4W=0x33, ImmExtW=0x44, RdW=7, ResultSrcW stepping 00→01→10→11 over 4 cycles. Required: ResultW follows 0x11, 0x22, 0x33, 0x44, and x7 ends at 0x44.
- **x0 protection:** RegWriteW=1, ValidW=1, RdW=0, ALUResultW=0xFFFFFFFF, Rs1D=Rs2D=0. Required: RD1D=RD2D=0 during and after the write.
- **Same-cycle bypass:** write 0xCAFE0001 to x9 with Rs1D=Rs2D=9 in the same cycle. Required: RD1D=RD2D=0xCAFE0001 in that cycle, and the array reads the same value in the next cycle.
- **Flushed instruction:** RegWriteW=1, ValidW=0, RdW=3, ALUResultW=0x55. Required: x3 unchanged, no bypass, InstretCnt unchanged, CycleCnt +1.
- **Counter wrap:** with COUNT_WIDTH=4, run 20 cycles with ValidW toggling every cycle, starting high. Required: CycleCnt=4 (20 mod 16) and InstretCnt=10.

Source files
------------

// File: rtl/wb_regfile.sv
// Writeback stage: selects the final result of the instruction in W, commits it
// to the 32-entry integer register file and serves the two decode-stage read
// ports with same-cycle write-through bypass. Also keeps the cycle and
// retired-instruction counters used for performance monitoring.
module wb_regfile #(
    parameter int DATA_WIDTH  = 32,
    parameter int ADDR_WIDTH  = 5,
    parameter int COUNT_WIDTH = 64
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   RegWriteW,
    input  logic [1:0]             ResultSrcW,
    input  logic                   ValidW,
    input  logic [ADDR_WIDTH-1:0]  RdW,
    input  logic [DATA_WIDTH-1:0]  ALUResultW,
    input  logic [DATA_WIDTH-1:0]  ReadDataW,
    input  logic [DATA_WIDTH-1:0]  PCPlus4W,
    input  logic [DATA_WIDTH-1:0]  ImmExtW,
    input  logic [ADDR_WIDTH-1:0]  Rs1D,
    input  logic [ADDR_WIDTH-1:0]  Rs2D,
    output logic [DATA_WIDTH-1:0]  ResultW,
    output logic [DATA_WIDTH-1:0]  RD1D,
    output logic [DATA_WIDTH-1:0]  RD2D,
    output logic [COUNT_WIDTH-1:0] CycleCnt,
    output logic [COUNT_WIDTH-1:0] InstretCnt
);

    localparam int DEPTH = 2 ** ADDR_WIDTH;
    localparam logic [COUNT_WIDTH-1:0] CNT_ONE = {{(COUNT_WIDTH-1){1'b0}}, 1'b1};

    // Entry 0 is cleared by reset and never written, so it always holds zero;
    // the read ports still special-case index 0 so x0 never bypasses.
    logic [DATA_WIDTH-1:0]  regs_q [DEPTH];
    logic [COUNT_WIDTH-1:0] cycle_q, cycle_d;
    logic [COUNT_WIDTH-1:0] instret_q, instret_d;
    logic                   we;

    // Final writeback value; independent of RegWriteW so forwarding can use it.
    always_comb begin
        ResultW = ALUResultW;
        unique case (ResultSrcW)
            2'b00: ResultW = ALUResultW;
            2'b01: ResultW = ReadDataW;
            2'b10: ResultW = PCPlus4W;
            2'b11: ResultW = ImmExtW;
        endcase
    end

    // Commit only real, enabled instructions to a non-zero destination while out of reset.
    assign we = reset && RegWriteW && ValidW && (RdW != '0);

    // Register array: cleared on reset (dropping any concurrent write), else commit.
    always_ff @(posedge clk) begin
        if (!reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                regs_q[i] <= '0;
            end
        end else if (we) begin
            regs_q[RdW] <= ResultW;
        end
    end

    // Counter next-state: every cycle counts, only valid W-stage slots retire.
    always_comb begin
        cycle_d   = cycle_q + CNT_ONE;
        instret_d = instret_q;
        if (ValidW) begin
            instret_d = instret_q + CNT_ONE;
        end
    end

    // Counter registers; wrap naturally at the counter width.
    always_ff @(posedge clk) begin
        if (!reset) begin
            cycle_q   <= '0;
            instret_q <= '0;
        end else begin
            cycle_q   <= cycle_d;
            instret_q <= instret_d;
        end
    end

    assign CycleCnt   = cycle_q;
    assign InstretCnt = instret_q;

    // Two identical read ports: zero for x0 or during reset, bypass on a
    // matching commit in this cycle, otherwise the stored value.
    logic [ADDR_WIDTH-1:0] rd_idx  [2];
    logic [DATA_WIDTH-1:0] rd_data [2];

    assign rd_idx[0] = Rs1D;
    assign rd_idx[1] = Rs2D;

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_read_port
            // Read mux with write-through bypass for port gi.
            always_comb begin
                rd_data[gi] = regs_q[rd_idx[gi]];
                if (!reset || (rd_idx[gi] == '0)) begin
                    rd_data[gi] = '0;
                end else if (we && (RdW == rd_idx[gi])) begin
                    rd_data[gi] = ResultW;
                end
            end
        end
    endgenerate

    assign RD1D = rd_data[0];
    assign RD2D = rd_data[1];

endmodule

// File: tb/tb_wb_regfile.sv
// Self-checking bench for wb_regfile: directed scenarios plus randomized
// traffic compared against an architectural model of the register file and
// counters. A second instance with 4-bit counters exercises wrap-around.
module tb_wb_regfile;

    localparam int DW  = 32;
    localparam int AW  = 5;
    localparam int CW  = 64;
    localparam int CWS = 4;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          reset;
    logic          RegWriteW;
    logic [1:0]    ResultSrcW;
    logic          ValidW;
    logic [AW-1:0] RdW, Rs1D, Rs2D;
    logic [DW-1:0] ALUResultW, ReadDataW, PCPlus4W, ImmExtW;

    logic [DW-1:0]  ResultW, RD1D, RD2D;
    logic [CW-1:0]  CycleCnt, InstretCnt;
    logic [DW-1:0]  ResultW_s, RD1D_s, RD2D_s;
    logic [CWS-1:0] CycleCnt_s, InstretCnt_s;

    wb_regfile #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .COUNT_WIDTH(CW)) dut (
        .clk(clk), .reset(reset), .RegWriteW(RegWriteW), .ResultSrcW(ResultSrcW),
        .ValidW(ValidW), .RdW(RdW), .ALUResultW(ALUResultW), .ReadDataW(ReadDataW),
        .PCPlus4W(PCPlus4W), .ImmExtW(ImmExtW), .Rs1D(Rs1D), .Rs2D(Rs2D),
        .ResultW(ResultW), .RD1D(RD1D), .RD2D(RD2D),
        .CycleCnt(CycleCnt), .InstretCnt(InstretCnt)
    );

    wb_regfile #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .COUNT_WIDTH(CWS)) dut_w (
        .clk(clk), .reset(reset), .RegWriteW(RegWriteW), .ResultSrcW(ResultSrcW),
        .ValidW(ValidW), .RdW(RdW), .ALUResultW(ALUResultW), .ReadDataW(ReadDataW),
        .PCPlus4W(PCPlus4W), .ImmExtW(ImmExtW), .Rs1D(Rs1D), .Rs2D(Rs2D),
        .ResultW(ResultW_s), .RD1D(RD1D_s), .RD2D(RD2D_s),
        .CycleCnt(CycleCnt_s), .InstretCnt(InstretCnt_s)
    );

    int n_vec = 0;
    int n_err = 0;

    // Architectural model: register contents and counters as plain integers.
    logic [DW-1:0] m_regs [32];
    longint unsigned m_cyc  = 0;
    longint unsigned m_inst = 0;
    bit m_known = 0;

    task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [DW-1:0] m_result();
        logic [DW-1:0] srcs [4];
        srcs[0] = ALUResultW;
        srcs[1] = ReadDataW;
        srcs[2] = PCPlus4W;
        srcs[3] = ImmExtW;
        return srcs[ResultSrcW];
    endfunction

    function automatic bit m_commits();
        return (reset === 1'b1) && RegWriteW && ValidW && (RdW != 0);
    endfunction

    function automatic logic [DW-1:0] m_read(input logic [AW-1:0] idx);
        if (reset !== 1'b1 || idx == 0) return '0;
        if (m_commits() && RdW == idx) return m_result();
        return m_regs[idx];
    endfunction

    task automatic drive(input logic rst, input logic rw, input logic [1:0] src, input logic vld,
                         input logic [AW-1:0] rd, input logic [DW-1:0] alu,
                         input logic [AW-1:0] rs1, input logic [AW-1:0] rs2);
        reset      = rst;
        RegWriteW  = rw;
        ResultSrcW = src;
        ValidW     = vld;
        RdW        = rd;
        ALUResultW = alu;
        Rs1D       = rs1;
        Rs2D       = rs2;
    endtask

    // One transaction: check all outputs against the model, then clock and advance the model.
    task automatic step();
        #1;
        if (m_known) begin
            check_val("result", ResultW, m_result());
            check_val("rd1", RD1D, m_read(Rs1D));
            check_val("rd2", RD2D, m_read(Rs2D));
            check_val("cycle", CycleCnt, m_cyc);
            check_val("instret", InstretCnt, m_inst);
            check_val("rd1_w", RD1D_s, m_read(Rs1D));
            check_val("cycle_w", CycleCnt_s, m_cyc % 16);
            check_val("instret_w", InstretCnt_s, m_inst % 16);
            $display("txn t=%0t rst=%0b rw=%0b v=%0b src=%0d rd=%0d res=%h rs1=%0d rd1=%h rs2=%0d rd2=%h cyc=%0d ret=%0d",
                     $time, reset, RegWriteW, ValidW, ResultSrcW, RdW, ResultW,
                     Rs1D, RD1D, Rs2D, RD2D, CycleCnt, InstretCnt);
        end
        @(posedge clk);
        if (reset !== 1'b1) begin
            for (int i = 0; i < 32; i++) m_regs[i] = '0;
            m_cyc  = 0;
            m_inst = 0;
        end else begin
            if (m_commits()) m_regs[RdW] = m_result();
            m_cyc++;
            if (ValidW) m_inst++;
        end
        m_known = 1;
        @(negedge clk);
    endtask

    logic [DW-1:0] src_exp [4];
    longint unsigned inst_before;

    initial begin
        ReadDataW = 32'h22;
        PCPlus4W  = 32'h33;
        ImmExtW   = 32'h44;

        // Power-up reset for two cycles.
        drive(1'b0, 1'b0, 2'b00, 1'b0, 5'd0, 32'h0, 5'd0, 5'd0);
        step();
        step();

        // Reset clear: write x5, reset for one cycle, then read back zero.
        drive(1'b1, 1'b1, 2'b00, 1'b1, 5'd5, 32'hDEADBEEF, 5'd5, 5'd5);
        step();
        reset = 1'b0;
        step();
        drive(1'b1, 1'b0, 2'b00, 1'b1, 5'd0, 32'h0, 5'd5, 5'd5);
        #1;
        check_val("rst_x5", RD1D, 32'h0);
        check_val("rst_cyc0", CycleCnt, 64'd0);
        check_val("rst_ret0", InstretCnt, 64'd0);
        step();
        #1;
        check_val("rst_cyc1", CycleCnt, 64'd1);

        // Source select walk with writes to x7.
        src_exp[0] = 32'h11; src_exp[1] = 32'h22; src_exp[2] = 32'h33; src_exp[3] = 32'h44;
        for (int s = 0; s < 4; s++) begin
            drive(1'b1, 1'b1, 2'(s), 1'b1, 5'd7, 32'h11, 5'd1, 5'd2);
            #1;
            check_val("srcsel", ResultW, src_exp[s]);
            step();
        end
        drive(1'b1, 1'b0, 2'b00, 1'b1, 5'd0, 32'h11, 5'd7, 5'd7);
        #1;
        check_val("x7_final", RD1D, 32'h44);
        step();

        // x0 protection during and after a write attempt.
        drive(1'b1, 1'b1, 2'b00, 1'b1, 5'd0, 32'hFFFFFFFF, 5'd0, 5'd0);
        #1;
        check_val("x0_rd1", RD1D, 32'h0);
        check_val("x0_rd2", RD2D, 32'h0);
        step();
        RegWriteW = 1'b0;
        #1;
        check_val("x0_after", RD1D, 32'h0);
        step();

        // Same-cycle bypass on both ports, then array read.
        drive(1'b1, 1'b1, 2'b00, 1'b1, 5'd9, 32'hCAFE0001, 5'd9, 5'd9);
        #1;
        check_val("byp_rd1", RD1D, 32'hCAFE0001);
        check_val("byp_rd2", RD2D, 32'hCAFE0001);
        step();
        RegWriteW = 1'b0;
        #1;
        check_val("byp_array", RD2D, 32'hCAFE0001);
        step();

        // Flushed instruction: no write, no bypass, no retire.
        drive(1'b1, 1'b1, 2'b00, 1'b1, 5'd3, 32'h12, 5'd0, 5'd0);
        step();
        drive(1'b1, 1'b1, 2'b00, 1'b0, 5'd3, 32'h55, 5'd3, 5'd3);
        #1;
        check_val("flush_nobyp", RD1D, 32'h12);
        inst_before = m_inst;
        step();
        RegWriteW = 1'b0;
        #1;
        check_val("flush_x3", RD1D, 32'h12);
        check_val("flush_ret", InstretCnt, inst_before);

        // Randomized traffic with occasional mid-stream reset.
        for (int n = 0; n < 250; n++) begin
            reset      = ($urandom_range(0, 39) != 0);
            RegWriteW  = 1'($urandom);
            ValidW     = ($urandom_range(0, 3) != 0);
            ResultSrcW = 2'($urandom);
            RdW        = 5'($urandom);
            ALUResultW = $urandom;
            ReadDataW  = $urandom;
            PCPlus4W   = $urandom;
            ImmExtW    = $urandom;
            Rs1D       = ($urandom_range(0, 1) != 0) ? RdW : 5'($urandom);
            Rs2D       = ($urandom_range(0, 2) == 0) ? RdW : 5'($urandom);
            step();
        end

        // Counter wrap: 20 cycles after reset with ValidW toggling, starting high.
        drive(1'b0, 1'b0, 2'b00, 1'b0, 5'd0, 32'h0, 5'd0, 5'd0);
        step();
        reset = 1'b1;
        for (int n = 0; n < 20; n++) begin
            ValidW    = ((n % 2) == 0);
            RegWriteW = 1'($urandom);
            RdW       = 5'($urandom);
            step();
        end
        #1;
        check_val("wrap_cyc4", CycleCnt_s, 64'd4);
        check_val("wrap_ret4", InstretCnt_s, 64'd10);
        check_val("wrap_cyc64", CycleCnt, 64'd20);
        check_val("wrap_ret64", InstretCnt, 64'd10);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    // Global watchdog so the run always terminates.
    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, want completion");
        $fatal(1, "timeout");
    end

endmodule
